// File: rtl/sample_txuart_pkg.sv
// Shared definitions for the sample TX UART: state encoding and 8N1 frame constants.
package sample_txuart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Word-level sequencing phases; the serializer's own state fills in START/DATA/STOP.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_WAIT,
        PH_SEND
    } phase_t;

    localparam int   DATA_BITS   = 8;
    localparam int   FRAME_BITS  = 10;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic logic line_level(input state_t s, input logic lsb);
        case (s)
            START:   return START_LEVEL;
            DATA:    return lsb;
            default: return STOP_LEVEL;
        endcase
    endfunction

endpackage

// File: rtl/sample_txuart_txuart.sv
// Single-byte 8N1 serializer with byte valid/ready; tx is registered from the next state.
module txuart
    import sample_txuart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 52
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx,
    output state_t     state
);

    localparam int             CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(CLKS_PER_BIT - 1);

    state_t        state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    pos, pos_n;     // frame position: 0 start, 1..8 data, 9 stop
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            pos   <= '0;
            shreg <= '0;
            tx    <= STOP_LEVEL;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pos   <= pos_n;
            shreg <= shreg_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pos_n     = pos;
        shreg_n   = shreg;
        byte_done = 1'b0;
        if (state != IDLE) cnt_n = cnt - 1'b1;
        case (state)
            IDLE: begin
                if (byte_valid) begin
                    state_n = START;
                    shreg_n = byte_data;
                    cnt_n   = RELOAD;
                    pos_n   = '0;
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_n = DATA;
                    cnt_n   = RELOAD;
                    pos_n   = 4'd1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_n   = RELOAD;
                    shreg_n = shreg >> 1;
                    if (pos == 4'(DATA_BITS)) begin
                        state_n = STOP;
                        pos_n   = 4'(FRAME_BITS - 1);
                    end else begin
                        pos_n = pos + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_n   = IDLE;
                    byte_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level follows the state being entered so tx lines up with the state register.
        tx_n       = line_level(state_n, shreg_n[0]);
        byte_ready = (state == IDLE);
    end

endmodule

// File: rtl/sample_txuart.sv
// Sample-word UART transmitter: latches a word, sends it low byte first as 8N1 frames.
// Build option: define SAMPLE_TXUART_FLOW_CTRL_EN to make tx_hold pause between bytes.
module sample_txuart
    import sample_txuart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 52,
    parameter int BITS         = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    input  logic            tx_hold,
    output logic            tx,
    output logic            busy,
    output logic [15:0]     words_sent
);

    localparam int            NBYTES = BITS / 8;
    localparam int            BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST   = BW'(NBYTES - 1);

    // Handshake: a word moves when in_valid && in_ready at a rising edge; in_ready is
    // high only in IDLE, so in_valid and in_data are don't-care while a word is in flight.
    phase_t          phase, phase_n;
    logic [BITS-1:0] word_q, word_n;
    logic [BW-1:0]   idx, idx_n;
    logic [15:0]     ws_n;
    logic            byte_valid, byte_ready, byte_done, hold;
    state_t          ser_state;
    state_t          unused_dbg_state;

`ifdef SAMPLE_TXUART_FLOW_CTRL_EN
    assign hold = tx_hold;
`else
    logic unused_hold;
    assign unused_hold = tx_hold;
    assign hold        = 1'b0;
`endif

    txuart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_txuart (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (word_q[7:0]),
        .byte_ready (byte_ready),
        .byte_done  (byte_done),
        .tx         (tx),
        .state      (ser_state)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase      <= PH_IDLE;
            word_q     <= '0;
            idx        <= '0;
            words_sent <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            phase      <= phase_n;
            word_q     <= word_n;
            idx        <= idx_n;
            words_sent <= ws_n;
            in_ready   <= (phase_n == PH_IDLE);
            busy       <= (phase_n != PH_IDLE);
        end
    end

    always_comb begin
        phase_n    = phase;
        word_n     = word_q;
        idx_n      = idx;
        ws_n       = words_sent;
        byte_valid = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (in_valid && in_ready) begin
                    word_n  = in_data;
                    idx_n   = '0;
                    phase_n = PH_WAIT;
                end
            end
            PH_WAIT: begin
                if (!hold && byte_ready) begin
                    byte_valid = 1'b1;
                    phase_n    = PH_SEND;
                end
            end
            PH_SEND: begin
                if (byte_done) begin
                    // Next byte is always presented from the bottom of the latch.
                    word_n = word_q >> 8;
                    if (idx == LAST) begin
                        phase_n = PH_IDLE;
                        ws_n    = words_sent + 16'd1;
                    end else begin
                        idx_n   = idx + 1'b1;
                        phase_n = PH_WAIT;
                    end
                end
            end
            default: phase_n = PH_IDLE;
        endcase
    end

    always_comb begin
        case (phase)
            PH_IDLE: unused_dbg_state = IDLE;
            PH_WAIT: unused_dbg_state = WAIT;
            default: unused_dbg_state = ser_state;
        endcase
    end

endmodule

// File: tb/tb_sample_txuart.sv
// Bench for sample_txuart: per-cycle waveform scoreboard, UART decode, table + random words.
module tb_sample_txuart;

    localparam int C    = 4;
    localparam int BITS = 16;
    localparam int NB   = BITS / 8;
`ifdef SAMPLE_TXUART_FLOW_CTRL_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_valid = 1'b0;
    logic        tx_hold  = 1'b0;
    logic [15:0] in_data  = '0;
    logic        in_ready, tx, busy;
    logic [15:0] words_sent;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [2:0]  exp_q[$];      // {tx, busy, in_ready} per cycle after accept
    logic [15:0] ws_model = '0;

    typedef struct {
        logic [15:0] data;
        int          hold_at;
        int          hold_len;
        bit          b2b;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
    } vec_t;
    vec_t tbl[5];

    sample_txuart #(.CLKS_PER_BIT(C), .BITS(BITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_hold    (tx_hold),
        .tx         (tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit hold_fn(input int k, input int at, input int len);
        return (k >= at) && (k < at + len);
    endfunction

    // Reference: every byte costs one WAIT cycle (plus one per held cycle), then C cycles
    // of start, 8*C of data LSB first, C of stop; the word ends with one idle cycle.
    function automatic void build_exp(input logic [15:0] w, input int hold_at, input int hold_len);
        int         k;
        logic [7:0] b;
        exp_q.delete();
        k = 1;
        for (int n = 0; n < NB; n++) begin
            b = 8'(w >> (8 * n));
            while (FLOW && hold_fn(k, hold_at, hold_len)) begin
                exp_q.push_back(3'b110);
                k++;
            end
            exp_q.push_back(3'b110);
            k++;
            repeat (C) exp_q.push_back(3'b010);
            for (int i = 0; i < 8; i++) repeat (C) exp_q.push_back({b[i], 2'b10});
            repeat (C) exp_q.push_back(3'b110);
            k += 10 * C;
        end
        exp_q.push_back(3'b101);
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with in_valid/in_data already presenting w. Compares every cycle
    // until the word is done, then decodes the captured line like a UART receiver.
    task automatic run_word(input logic [15:0] w, input int hold_at, input int hold_len,
                            input logic nxt_valid, input logic [15:0] nxt_data,
                            input int abort_at, output logic [15:0] dec, output int nbytes);
        logic       txs[$];
        logic [2:0] e, got;
        logic [7:0] b;
        int         k, j;
        dec    = '0;
        nbytes = 0;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        build_exp(w, hold_at, hold_len);
        @(posedge clk);
        k = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            k++;
            e   = exp_q.pop_front();
            got = {tx, busy, in_ready};
            check($sformatf("cyc%0d_tx_busy_ready word=%h", k, w), 32'(got), 32'(e));
            txs.push_back(tx);
            if (k == abort_at) return;
            if (exp_q.size() == 0) begin
                ws_model++;
                check("words_sent", 32'(words_sent), 32'(ws_model));
                in_valid = nxt_valid;
                in_data  = nxt_data;
                tx_hold  = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 16'($urandom);
                tx_hold  = hold_fn(k, hold_at, hold_len);
            end
        end
        j = 1;
        while (j + 10 * C <= txs.size()) begin
            if (txs[j] == 1'b0 && txs[j-1] == 1'b1) begin
                for (int i = 0; i < 8; i++) b[i] = txs[j + C * (1 + i) + C / 2];
                check("stop_bit", 32'(txs[j + 9 * C + C / 2]), 32'd1);
                if (nbytes < 2) dec[8 * nbytes +: 8] = b;
                nbytes++;
                j += 10 * C;
            end else begin
                j++;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] dec, cur, nxt;
        int          nb, h_at, h_len;
        bit          b2b;

        tbl[0] = '{16'hA55A, 0,  0,   1'b0, 8'h5A, 8'hA5};
        tbl[1] = '{16'h0001, 0,  0,   1'b1, 8'h01, 8'h00};
        tbl[2] = '{16'hFFFF, 0,  0,   1'b0, 8'hFF, 8'hFF};
        tbl[3] = '{16'h3C96, 10, 100, 1'b0, 8'h96, 8'h3C};
        tbl[4] = '{16'h0F80, 1,  15,  1'b0, 8'h80, 8'h0F};

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_words_sent", 32'(words_sent), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);

        in_valid = 1'b1;
        in_data  = tbl[0].data;
        for (int i = 0; i < 5; i++) begin
            run_word(tbl[i].data, tbl[i].hold_at, tbl[i].hold_len, tbl[i].b2b,
                     (i < 4) ? tbl[i+1].data : 16'h0000, 0, dec, nb);
            check($sformatf("tbl%0d_nbytes", i), 32'(nb), 32'd2);
            check($sformatf("tbl%0d_bytes", i), 32'(dec), 32'({tbl[i].exp_b1, tbl[i].exp_b0}));
            if (!tbl[i].b2b && i < 4) begin
                repeat (3) begin
                    @(negedge clk);
                    check("idle_gap_ready", 32'(in_ready), 32'd1);
                    check("idle_gap_tx", 32'(tx), 32'd1);
                end
                in_valid = 1'b1;
                in_data  = tbl[i+1].data;
            end
        end

        @(negedge clk);
        cur      = 16'($urandom);
        in_valid = 1'b1;
        in_data  = cur;
        for (int r = 0; r < 20; r++) begin
            nxt   = 16'($urandom);
            b2b   = (r < 19) ? bit'($urandom_range(0, 1)) : 1'b0;
            h_at  = $urandom_range(1, 60);
            h_len = $urandom_range(0, 80);
            run_word(cur, h_at, h_len, b2b, nxt, 0, dec, nb);
            check("rand_nbytes", 32'(nb), 32'd2);
            check("rand_bytes", 32'(dec), 32'(cur));
            if (!b2b && r < 19) begin
                @(negedge clk);
                check("rand_idle_ready", 32'(in_ready), 32'd1);
                in_valid = 1'b1;
                in_data  = nxt;
            end
            cur = nxt;
        end

        // Reset in the middle of byte 1's start bit discards the word.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        run_word(16'hBEEF, 0, 0, 1'b0, 16'h0000, 10 * C + 4, dec, nb);
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_words_sent", 32'(words_sent), 32'd0);
        ws_model = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx", 32'(tx), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tx_hold  = 1'b0;
        run_word(16'h1234, 0, 0, 1'b0, 16'h0000, 0, dec, nb);
        check("post_reset_bytes", 32'(dec), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_txuart.md
# sample_txuart

Streams fixed-width audio samples out over an 8N1 UART, low byte first, as the return path of the dacboard serial link. Accepts one sample word per valid/ready handshake, splits it into BITS/8 bytes, serializes each byte with start/stop framing at a programmable bit period, and pauses between bytes while the host asserts a hold request. Sits between a capture FIFO (read side) and the UART TX pin.

## Interface
- CLKS_PER_BIT, default 52: clock cycles per UART bit (12 MHz / 230 400 baud); legal range ≥2.
- BITS, default 16: sample width; must be a nonzero multiple of 8.
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample word available.
- in_data  input  BITS  sample word; bits [7:0] transmitted first.
- in_ready  output  1  block can accept a word this cycle.
- tx_hold  input  1  host flow control, active-high: do not start another byte.
- tx  output  1  UART serial line, idle high.
- busy  output  1  word in flight (any state except IDLE).
- words_sent  output  16  count of fully transmitted words, wraps at 65535→0.

## Operation
- States: IDLE, WAIT, START, DATA, STOP.
- IDLE: in_ready=1, tx=1. On in_valid&&in_ready latch in_data into shift register, byte index=0, go WAIT.
- WAIT: tx=1. If tx_hold=0 go START, else remain. tx_hold is sampled only in WAIT; a byte already started always completes.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx=current LSB of byte for CLKS_PER_BIT cycles per bit, shift right, 8 bits, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then: if byte index < BITS/8−1, increment, go WAIT; else increment words_sent, go IDLE.
- in_data changes while busy have no effect; in_valid while busy is ignored (in_ready=0).
- Baud counter counts CLKS_PER_BIT−1 down to 0; width $clog2(CLKS_PER_BIT). Reloads on each state entry.
- Reset (any time, including mid-byte): tx=1, in_ready=1 after release, busy=0, words_sent=0, state IDLE, current word discarded.

## Timing
- Accept cycle is cycle 0 (tx high). With tx_hold=0: WAIT at cycle 1, start bit driven cycles 2..CLKS_PER_BIT+1.
- One byte occupies exactly 10·CLKS_PER_BIT cycles from START entry to STOP exit; WAIT adds 1 cycle per byte when not held.
- Unheld word: (BITS/8)·(10·CLKS_PER_BIT+1) cycles from accept to IDLE; 16-bit at default: 1042 cycles; in_ready high next cycle.
- tx_hold rising during DATA/STOP: current byte finishes; next WAIT holds until tx_hold=0, START entered the cycle after tx_hold is seen low.
- words_sent updates on the STOP→IDLE transition cycle; busy falls the same cycle.
- All outputs registered; tx has no combinational path from any input.

## Configuration
- SAMPLE_TXUART_FLOW_CTRL_EN defined: tx_hold behaves as above.
- Not defined: tx_hold port remains but is ignored; WAIT always exits after one cycle, so timing equals the unheld case.

## Structure
- Shared package: state encoding constants (IDLE..STOP), UART frame constants (DATA_BITS=8, START level 0, STOP level 1, FRAME_BITS=10).
- Sub-module txuart: single-byte 8N1 serializer (baud counter, bit counter, START/DATA/STOP) with byte valid/ready; sample_txuart owns the word latch, byte sequencing, WAIT/flow control and words_sent. Mirrors the existing rxuart.

## Test plan
- CLKS_PER_BIT=4, send 16'hA55A, tx_hold=0 -> tx shows 0,01011010 LSB-first (0,1,0,1,1,0,1,0),1 then 0,10100101 LSB-first,1; each bit 4 cycles; words_sent 0→1; in_ready high 82 cycles after accept.
- Back-to-back words 16'h0001, 16'hFFFF with in_valid held -> second accepted the first cycle in_ready returns; decoded bytes 01,00,FF,FF.
- tx_hold asserted mid-DATA of byte 0 for 100 cycles -> byte 0 completes intact, tx stays high ≥100 cycles, byte 1 starts the cycle after hold seen low; with macro undefined, no gap.
- reset_n low mid-start-bit of byte 1 -> tx=1 immediately, busy=0, words_sent=0; after release new word 16'h1234 transmits cleanly.
- 65536 words (CLKS_PER_BIT=2) -> words_sent wraps to 0.
- in_valid during busy with changing in_data -> ignored; transmitted bytes match latched word.
